// File: rtl/dso_pkg.sv
// dso_pkg: shared types and constants for the DSO capture block.
//   state_e     acquisition state machine encoding
//   DSO_DW/AW   default sample and buffer address widths
//   SLOPE_*     trig_slope encoding
package dso_pkg;

  localparam int DSO_DW = 8;
  localparam int DSO_AW = 10;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/dso_trigger.sv
// dso_trigger: level/slope crossing detector plus force-trigger latch.
//   clock, reset_n   system clock, async active-low reset
//   armed            capture FSM is in ARMED (only state that accepts force_trig)
//   smp_en           sample strobe; consumes a pending forced trigger
//   arm              new acquisition; drops any pending forced trigger
//   force_trig       single-cycle force request
//   prev_sample      previously written sample
//   adc_data         current sample
//   trig_level       unsigned threshold
//   trig_slope       SLOPE_RISE / SLOPE_FALL
//   trig_hit         crossing or force present (caller qualifies with ARMED & smp_en)
module dso_trigger
  import dso_pkg::*;
#(
  parameter int DW = DSO_DW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          armed,
  input  logic          smp_en,
  input  logic          arm,
  input  logic          force_trig,
  input  logic [DW-1:0] prev_sample,
  input  logic [DW-1:0] adc_data,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_slope,
  output logic          trig_hit
);

  logic force_q;
  logic rise_x;
  logic fall_x;

  // A force pulse that lands between strobes is held so the next sample
  // becomes the trigger sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      force_q <= 1'b0;
    end else if (arm || smp_en) begin
      force_q <= 1'b0;
    end else if (armed && force_trig) begin
      force_q <= 1'b1;
    end
  end

  assign rise_x = (prev_sample < trig_level) && (adc_data >= trig_level);
  assign fall_x = (prev_sample > trig_level) && (adc_data <= trig_level);

  always_comb begin
    trig_hit = force_trig || force_q;
    if (trig_slope == SLOPE_RISE) trig_hit = trig_hit || rise_x;
    else                          trig_hit = trig_hit || fall_x;
  end

endmodule

// File: rtl/dso_capture.sv
// dso_capture: samples adc_data on each rising edge of the divided sample
// clock into a circular buffer, triggers on a level crossing (or force),
// keeps PRE_DEPTH samples ahead of the trigger and freezes for readout.
//   clock, reset_n   system clock, async active-low reset
//   sclk_in          divided sample clock, synchronous to clock
//   adc_data         ADC sample
//   arm              start acquisition (wins over a coincident sample)
//   force_trig       force a trigger while ARMED
//   trig_level       unsigned threshold; trig_slope 0=rise 1=fall
//   rd_addr          read offset from the oldest sample of the frame
//   rd_data          registered buffer read
//   busy             PRE/ARMED/POST; done: DONE
//   trig_addr        physical address of the trigger sample
module dso_capture
  import dso_pkg::*;
#(
  parameter int DW        = DSO_DW,
  parameter int AW        = DSO_AW,
  parameter int PRE_DEPTH = 256
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          sclk_in,
  input  logic [DW-1:0] adc_data,
  input  logic          arm,
  input  logic          force_trig,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_slope,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_addr
);

  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_DEPTH);
  localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE_DEPTH);

  state_e        state_q, state_d;
  logic          sclk_d;
  logic          smp_en;
  logic          wr_en;
  logic          take_trig;
  logic          trig_hit;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] pre_cnt;
  logic [AW-1:0] post_cnt;
  logic [DW-1:0] prev_sample;
  logic [AW-1:0] rd_idx;
  logic [DW-1:0] mem [DEPTH];

  assign smp_en = sclk_in && !sclk_d;

  dso_trigger #(.DW(DW)) u_trigger (
    .clock       (clock),
    .reset_n     (reset_n),
    .armed       (state_q == ARMED),
    .smp_en      (smp_en),
    .arm         (arm),
    .force_trig  (force_trig),
    .prev_sample (prev_sample),
    .adc_data    (adc_data),
    .trig_level  (trig_level),
    .trig_slope  (trig_slope),
    .trig_hit    (trig_hit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    take_trig = 1'b0;
    if (arm) begin
      state_d = PRE;
    end else begin
      case (state_q)
        PRE: if (smp_en) begin
          wr_en = 1'b1;
          if (pre_cnt + AW'(1) == PRE_LAST) state_d = ARMED;
        end
        ARMED: if (smp_en) begin
          wr_en = 1'b1;
          if (trig_hit) begin
            take_trig = 1'b1;
            state_d   = (POST_LAST == AW'(1)) ? DONE : POST;
          end
        end
        POST: if (smp_en) begin
          wr_en = 1'b1;
          if (post_cnt + AW'(1) == POST_LAST) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_d      <= 1'b0;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      prev_sample <= '0;
      trig_addr   <= '0;
    end else begin
      sclk_d <= sclk_in;
      if (arm) begin
        pre_cnt  <= '0;
        post_cnt <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr      <= wr_ptr + AW'(1);
          prev_sample <= adc_data;
        end
        if (wr_en && state_q == PRE) pre_cnt <= pre_cnt + AW'(1);
        if (take_trig) begin
          trig_addr <= wr_ptr;
          post_cnt  <= AW'(1);
        end else if (wr_en && state_q == POST) begin
          post_cnt <= post_cnt + AW'(1);
        end
      end
    end
  end

  // NOTE: the sample storage has no reset; it maps onto a RAM macro and its
  // contents are only meaningful after a completed acquisition anyway.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= adc_data;
  end

  // Frame is addressed from its oldest sample, PRE_DEPTH before the trigger.
  assign rd_idx = trig_addr - PRE_LAST + rd_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= mem[rd_idx];
  end

  assign busy = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_dso_capture.sv
// tb_dso_capture: directed scenarios plus randomized acquisitions for
// dso_capture (DEPTH=16, PRE_DEPTH=4), checked every cycle against a
// behavioural model of the capture rules.
module tb_dso_capture;
  import dso_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int PRE   = 4;
  localparam int DEPTH = 16;
  localparam int POSTN = DEPTH - PRE;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          sclk_in = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          arm = 1'b0;
  logic          force_trig = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic          trig_slope = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;

  dso_capture #(.DW(DW), .AW(AW), .PRE_DEPTH(PRE)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sclk_in    (sclk_in),
    .adc_data   (adc_data),
    .arm        (arm),
    .force_trig (force_trig),
    .trig_level (trig_level),
    .trig_slope (trig_slope),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .trig_addr  (trig_addr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  int            m_wp = 0;
  bit            m_sclk_prev = 0;
  bit            m_active = 0;
  bit            m_trig = 0;
  bit            m_force_pend = 0;
  int            m_npre = 0;
  int            m_npost = 0;
  int            m_taddr = 0;
  logic [DW-1:0] m_prev = '0;
  logic [DW-1:0] m_rd = '0;
  bit            m_rd_valid = 0;

  function automatic bit crosses(input logic [DW-1:0] p, input logic [DW-1:0] c,
                                 input logic [DW-1:0] lvl, input logic slope);
    if (slope == SLOPE_RISE) return (p < lvl) && (c >= lvl);
    return (p > lvl) && (c <= lvl);
  endfunction

  function automatic bit m_finished();
    return m_trig && (m_npost == POSTN);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    bit strobe;
    int old;
    if (!reset_n) begin
      m_wp = 0; m_sclk_prev = 0; m_active = 0; m_trig = 0; m_force_pend = 0;
      m_npre = 0; m_npost = 0; m_taddr = 0; m_prev = '0; m_rd_valid = 0;
    end else begin
      strobe      = sclk_in && !m_sclk_prev;
      m_sclk_prev = sclk_in;
      m_rd_valid  = m_active && m_finished();
      m_rd        = m_mem[(m_taddr + DEPTH - PRE + int'(rd_addr)) % DEPTH];
      if (arm) begin
        m_active = 1; m_trig = 0; m_npre = 0; m_npost = 0; m_force_pend = 0;
      end else if (m_active && !m_finished() && strobe) begin
        old          = m_wp;
        m_mem[m_wp]  = adc_data;
        m_wp         = (m_wp + 1) % DEPTH;
        if (m_npre < PRE) begin
          m_npre++;
        end else if (!m_trig) begin
          if (crosses(m_prev, adc_data, trig_level, trig_slope) || force_trig || m_force_pend) begin
            m_trig  = 1;
            m_taddr = old;
            m_npost = 1;
          end
          m_force_pend = 0;
        end else begin
          m_npost++;
        end
        m_prev = adc_data;
      end else if (m_active && !m_trig && m_npre == PRE && force_trig) begin
        m_force_pend = 1;
      end
    end
  end

  // Compare process: outputs checked on every falling edge out of reset.
  always @(negedge clock) begin
    if (reset_n) begin
      check("busy", busy, m_active && !m_finished());
      check("done", done, m_active && m_finished());
      check("trig_addr", trig_addr, m_taddr);
      if (m_rd_valid) check("rd_data", rd_data, m_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [DW-1:0] hist[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    hist.delete();
  endtask

  // One sclk_in period: high for hi clocks, low for lo clocks (lo >= 1).
  task automatic sample(input logic [DW-1:0] v, input int hi, input int lo,
                        input bit force_gap, input bit with_arm);
    adc_data = v;
    sclk_in  = 1'b1;
    arm      = with_arm;
    tick(1);
    arm      = 1'b0;
    for (int k = 1; k < hi; k++) begin
      adc_data = DW'($urandom);
      tick(1);
    end
    sclk_in = 1'b0;
    if (force_gap) begin
      force_trig = 1'b1;
      tick(1);
      force_trig = 1'b0;
      tick(lo - 1);
    end else begin
      tick(lo);
    end
    if (with_arm) hist.delete();
    else          hist.push_back(v);
  endtask

  task automatic s4(input logic [DW-1:0] v, input bit force_gap);
    sample(v, 2, 2, force_gap, 1'b0);
  endtask

  task automatic check_frame(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      tick(1);
      check(name, rd_data, hist[hist.size() - DEPTH + i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // ---- reset state ----
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_rd_data", rd_data, 0);
    #3 reset_n = 1'b1;
    tick(2);

    // ---- ramp, rising trigger at level 10 ----
    trig_level = 8'd10; trig_slope = SLOPE_RISE;
    pulse_arm();
    n = 0;
    for (int v = 0; v < 40 && !done; v++) begin
      s4(DW'(v), 1'b0);
      n++;
    end
    check("ramp_done", done, 1);
    check("ramp_busy", busy, 0);
    check("ramp_nsamples", n, 22);
    check("ramp_trig_addr", trig_addr, 10);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      tick(1);
      check("ramp_frame", rd_data, 6 + i);
    end

    // ---- falling slope; PRE samples must not trigger ----
    trig_slope = SLOPE_FALL;
    pulse_arm();
    s4(8'd20, 0); s4(8'd5, 0); s4(8'd20, 0); s4(8'd5, 0);
    s4(8'd20, 0); s4(8'd15, 0); s4(8'd9, 0);
    for (int i = 0; i < 11; i++) s4(DW'(100 + i), 1'b0);
    check("fall_done", done, 1);
    check_frame("fall_frame");
    rd_addr = AW'(PRE);
    tick(1);
    check("fall_trig_sample", rd_data, 9);
    rd_addr = AW'(PRE - 1);
    tick(1);
    check("fall_before_trig", rd_data, 15);

    // ---- force_trig, constant data; force in PRE ignored ----
    trig_slope = SLOPE_RISE;
    pulse_arm();
    s4(8'h33, 1); s4(8'h33, 1); s4(8'h33, 0); s4(8'h33, 0);
    s4(8'h33, 0); s4(8'h33, 1);
    check("force_not_done", done, 0);
    n = 0;
    while (!done && n < 30) begin
      s4(8'h33, 1'b0);
      n++;
    end
    check("force_post_count", n, POSTN);

    // ---- sclk_in held high 50 clocks: one write only ----
    trig_level = 8'd200;
    pulse_arm();
    for (int i = 1; i <= 4; i++) s4(DW'(i), 1'b0);
    sample(8'd50, 50, 2, 1'b0, 1'b0);
    s4(8'd60, 0); s4(8'd61, 1);
    n = 0;
    while (!done && n < 30) begin
      s4(DW'(70 + n), 1'b0);
      n++;
    end
    check("hold_post_count", n, POSTN);
    check_frame("hold_frame");

    // ---- arm coincident with a sample during POST ----
    pulse_arm();
    for (int i = 1; i <= 4; i++) s4(DW'(i), 1'b0);
    s4(8'd5, 1);
    s4(8'd6, 0); s4(8'd7, 0); s4(8'd8, 0);
    sample(8'd9, 2, 2, 1'b0, 1'b1);
    check("rearm_busy", busy, 1);
    check("rearm_done", done, 0);
    s4(8'd10, 0); s4(8'd11, 1); s4(8'd12, 0); s4(8'd13, 1);
    n = 0;
    while (!done && n < 30) begin
      s4(DW'(14 + n), 1'b0);
      n++;
    end
    check("rearm_post_count", n, POSTN);
    check_frame("rearm_frame");
    rd_addr = AW'(PRE);
    tick(1);
    check("rearm_trig_sample", rd_data, 14);

    // ---- asynchronous reset mid-ARMED ----
    trig_level = 8'd250;
    pulse_arm();
    for (int i = 0; i < 6; i++) s4(DW'(i), 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_trig_addr", trig_addr, 0);
    check("arst_rd_data", rd_data, 0);
    tick(2);
    #2 reset_n = 1'b1;
    tick(2);

    // ---- randomized acquisitions ----
    for (int a = 0; a < 10; a++) begin
      trig_level = DW'($urandom);
      trig_slope = 1'($urandom);
      tick($urandom_range(1, 4));
      pulse_arm();
      n = 0;
      while (!done && n < 150) begin
        sample(DW'($urandom), $urandom_range(1, 3), $urandom_range(1, 3),
               (n > 40) || ($urandom_range(0, 15) == 0),
               $urandom_range(0, 59) == 0);
        n++;
      end
      check("rand_done", done, 1);
      for (int r = 0; r < 20; r++) begin
        rd_addr = AW'($urandom);
        tick(1);
      end
    end

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dso_capture.md
Name: dso_capture

Overview:
- Sample-side consumer of the DSO timebase divider output.
- Detects each rising edge of the divided sample clock and writes one ADC sample per edge into an internal circular buffer.
- Applies a level/slope trigger with fixed pre-trigger depth, then freezes the buffer for readout by the display/host logic.
- Sits between the timebase divider, the ADC input register and the waveform reader.

Parameters:
- DW, 8, ADC sample width in bits
- AW, 10, buffer address width; DEPTH = 2**AW samples
- PRE_DEPTH, 256, samples kept before the trigger; legal range 1..DEPTH-1

Ports:
- clock  in  1  system clock; also clocks the timebase divider
- reset_n  in  1  asynchronous active-low reset
- sclk_in  in  1  divided sample clock from the timebase, synchronous to clock
- adc_data  in  DW  ADC sample, valid at every clock edge
- arm  in  1  single-cycle pulse that starts an acquisition
- force_trig  in  1  single-cycle pulse that forces a trigger, accepted only in ARMED
- trig_level  in  DW  unsigned trigger threshold
- trig_slope  in  1  0 = rising, 1 = falling
- rd_addr  in  AW  read offset relative to the oldest sample of the frame
- rd_data  out  DW  buffer data, registered
- busy  out  1  high in PRE, ARMED and POST
- done  out  1  high in DONE
- trig_addr  out  AW  physical buffer address of the trigger sample

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-low: reset_n low clears all state immediately.
- Reset values:
  - State IDLE; busy=0, done=0.
  - rd_data=0, trig_addr=0.
  - wr_ptr=0, pre_cnt=0, post_cnt=0, prev_sample=0, sclk_d=0.
- Sample strobe:
  - sclk_d is sclk_in registered.
  - smp_en = sclk_in & ~sclk_d, giving exactly one clock-wide strobe per sclk_in rising edge.
  - Latency is one clock from the sclk_in rise.
- Write on smp_en in PRE, ARMED or POST:
  - mem[wr_ptr] <= adc_data.
  - wr_ptr increments modulo DEPTH, wrapping naturally at AW bits.
  - prev_sample <= adc_data.
  - No writes occur in IDLE or DONE, so the buffer is frozen.
- State machine (IDLE, PRE, ARMED, POST, DONE):
  - arm in any state:
    - next state PRE; pre_cnt=0, post_cnt=0, done=0.
    - arm has priority over smp_en in the same cycle; that cycle's sample is not written.
  - PRE: on each smp_en, pre_cnt increments; when the write makes pre_cnt = PRE_DEPTH, go to ARMED. force_trig is ignored here.
  - ARMED: a trigger fires on a cycle with smp_en when one of these holds:
    - rising: prev_sample < trig_level and adc_data >= trig_level.
    - falling: prev_sample > trig_level and adc_data <= trig_level.
    - force_trig=1; the trigger then applies to the next smp_en sample.
  - On a trigger:
    - the trigger sample is written; trig_addr <= wr_ptr (before increment).
    - post_cnt = 1; go to POST.
    - a force_trig pulse seen without smp_en is latched until the next smp_en.
  - Without a trigger in ARMED, writes continue and overwrite the oldest data, so the buffer always holds the last DEPTH samples.
  - POST: on each smp_en, post_cnt increments. When post_cnt reaches DEPTH-PRE_DEPTH, go to DONE with done=1.
  - DONE: holds until the next arm.
- Comparisons are unsigned at DW bits.
- Frame layout:
  - start_addr = trig_addr - PRE_DEPTH, modulo DEPTH.
  - The oldest sample is at start_addr; the trigger sample is at offset PRE_DEPTH.
- Read port:
  - rd_data <= mem[(start_addr + rd_addr) mod DEPTH], one clock latency, active in every state.
  - Data is defined only in DONE.
  - Reads never disturb the writer.
- sclk_in stuck high or low: no samples are taken and the state is held. No timeout.
- Reset mid-acquisition returns to IDLE. Buffer contents are not cleared.

Decomposition:
- Package dso_pkg holds:
  - state enum (IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4, 3 bits).
  - default DW/AW constants.
  - slope encoding constants (SLOPE_RISE=0, SLOPE_FALL=1).
- One sub-module, dso_trigger:
  - Combinational crossing compare of prev_sample, adc_data, trig_level and trig_slope.
  - Includes the force_trig latch.
  - Output is a single trig_hit bit.
- The buffer is an inferred single-write, single-registered-read RAM inside dso_capture.

Test Plan:
- AW=4 (DEPTH=16), PRE_DEPTH=4, sclk_in divide-by-4.
  - Stimulus: ramp adc_data 0,1,2…; arm; trig_level=10, rising.
  - Required: trig_addr holds sample 10; done after 12 post samples including the trigger; rd_addr 0..15 returns 6..21; busy falls as done rises.
- Falling slope.
  - Stimulus: samples 20,15,9,5 with trig_level=10.
  - Required: trigger on sample 9, not on 15; samples before PRE completes never trigger.
- force_trig.
  - Stimulus: constant adc_data=0x33; force_trig pulsed in ARMED between strobes.
  - Required: trigger on the next smp_en sample; done after 12 further post samples.
- Edge detect.
  - Stimulus: hold sclk_in high for 50 clocks.
  - Required: exactly one write; wr_ptr advances by 1.
- arm during POST.
  - Stimulus: arm pulse while in POST.
  - Required: state becomes PRE; done=0; pre_cnt restarts; arm coincident with smp_en writes nothing.
- Reset.
  - Stimulus: reset_n low mid-ARMED, asynchronous to clock.
  - Required: busy=0, done=0, trig_addr=0, rd_data=0 immediately, before the next clock edge.
